// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the ALU pipeline issue controller: instruction
// field positions, the NOP encoding, and scoreboard entry helpers.
package pipeline_ctrl_pkg;

  localparam int INSTR_W     = 32;
  localparam int REG_W       = 5;

  localparam int ALUOP_HI    = 31;
  localparam int ALUOP_LO    = 29;
  localparam int DATASRC_BIT = 28;
  localparam int WE_BIT      = 27;
  localparam int RD_HI       = 25;
  localparam int RD_LO       = 21;
  localparam int RS1_HI      = 20;
  localparam int RS1_LO      = 16;
  localparam int RS2_HI      = 15;
  localparam int RS2_LO      = 11;
  localparam int IMM_HI      = 15;
  localparam int IMM_LO      = 0;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  // One in-flight destination tracked by the hazard window.
  typedef struct packed {
    logic             we;
    logic [REG_W-1:0] rd;
  } sb_entry_t;

  // Destination record for an instruction leaving on instr_out.
  function automatic sb_entry_t sb_from_instr(input logic [INSTR_W-1:0] instr);
    sb_entry_t e;
    e.we = instr[WE_BIT];
    e.rd = instr[RD_HI:RD_LO];
    return e;
  endfunction

  // True when instr reads register r (rs2 only counts for register operands).
  function automatic logic reads_reg(input logic [INSTR_W-1:0] instr,
                                     input logic [REG_W-1:0]   r);
    return (instr[RS1_HI:RS1_LO] == r) ||
           (!instr[DATASRC_BIT] && (instr[RS2_HI:RS2_LO] == r));
  endfunction

endpackage

// File: rtl/pipeline_issue_ctrl_instr_fifo.sv
// Parameterised synchronous FIFO; occupancy counter separates full from empty.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Storage and pointer/occupancy update; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end else begin
        r_wr_ptr        <= r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_issue_ctrl.sv
// Issue controller for the 3-stage ALU pipeline: buffers instructions and
// inserts NOP bubbles while a source register has a write still in flight.
module pipeline_issue_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int HAZARD_DEPTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic [INSTR_W-1:0] instr_out,
  output logic               issue_valid,
  output logic               stall,
  output logic               busy,
  output logic [15:0]        stall_count
);

  logic               w_full;
  logic               w_empty;
  logic [INSTR_W-1:0] w_head;
  logic               w_hazard;
  logic               w_sb_any;
  logic               w_issue;
  logic               w_bubble;

  logic [INSTR_W-1:0] r_instr_out;
  logic               r_issue_valid;
  logic               r_stall;
  logic [15:0]        r_stall_count;
  sb_entry_t          r_sb [HAZARD_DEPTH];

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (w_issue),
    .din   (in_instr),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  // Hazard check of the FIFO head against the window and the instruction on instr_out.
  always_comb begin
    w_hazard = 1'b0;
    w_sb_any = 1'b0;
    for (int i = 0; i < HAZARD_DEPTH; i++) begin
      w_hazard = w_hazard | (r_sb[i].we & reads_reg(w_head, r_sb[i].rd));
      w_sb_any = w_sb_any | r_sb[i].we;
    end
    w_hazard = w_hazard |
               (r_issue_valid & r_instr_out[WE_BIT] &
                reads_reg(w_head, r_instr_out[RD_HI:RD_LO]));
  end

  assign w_issue  = ~w_empty & ~w_hazard;
  assign w_bubble = ~w_empty & w_hazard;

  // Issue registers, saturating bubble counter and the shifting hazard window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_out   <= NOP;
      r_issue_valid <= 1'b0;
      r_stall       <= 1'b0;
      r_stall_count <= 16'h0000;
      for (int i = 0; i < HAZARD_DEPTH; i++) begin
        r_sb[i] <= '0;
      end
    end else begin
      if (w_issue) begin
        r_instr_out   <= w_head;
        r_issue_valid <= 1'b1;
        r_sb[0]       <= sb_from_instr(w_head);
      end else begin
        r_instr_out   <= NOP;
        r_issue_valid <= 1'b0;
        r_sb[0]       <= '0;
      end
      r_stall <= w_bubble;
      if (w_bubble && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end else begin
        r_stall_count <= r_stall_count;
      end
      for (int i = 1; i < HAZARD_DEPTH; i++) begin
        r_sb[i] <= r_sb[i-1];
      end
    end
  end

  assign in_ready    = ~w_full;
  assign instr_out   = r_instr_out;
  assign issue_valid = r_issue_valid;
  assign stall       = r_stall;
  assign stall_count = r_stall_count;
  assign busy        = ~w_empty | w_sb_any;

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Self-checking bench for pipeline_issue_ctrl with a cycle-level reference model.
module tb_pipeline_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int HD    = 3;
  localparam int HD2   = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, issue_valid, stall, busy;
  logic [31:0] in_instr, instr_out;
  logic [15:0] stall_count;

  logic        in_valid2, in_ready2, issue_valid2, stall2, busy2;
  logic [31:0] in_instr2, instr_out2;
  logic [15:0] stall_count2;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic [31:0] m_instr;
  logic        m_valid, m_stall;
  int          m_cnt;
  longint      m_last_wr [32];
  longint      m_cyc = 0;

  always #5 clk = ~clk;

  pipeline_issue_ctrl #(.FIFO_DEPTH(DEPTH), .HAZARD_DEPTH(HD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .instr_out(instr_out), .issue_valid(issue_valid),
    .stall(stall), .busy(busy), .stall_count(stall_count));

  pipeline_issue_ctrl #(.FIFO_DEPTH(DEPTH), .HAZARD_DEPTH(HD2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_instr(in_instr2), .instr_out(instr_out2), .issue_valid(issue_valid2),
    .stall(stall2), .busy(busy2), .stall_count(stall_count2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Build an instruction; low16 carries rs2 in [15:11] or the immediate.
  function automatic logic [31:0] mk(input bit we, input bit ds, input int rd,
                                     input int rs1, input logic [15:0] low16);
    logic [31:0] v;
    v        = 32'h0;
    v[31:29] = 3'($urandom_range(7));
    v[28]    = ds;
    v[27]    = we;
    v[25:21] = 5'(rd);
    v[20:16] = 5'(rs1);
    v[15:0]  = low16;
    return v;
  endfunction

  function automatic logic [15:0] r2(input int rs2);
    return {5'(rs2), 11'($urandom_range(2047))};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_instr = 32'h0;
    m_valid = 1'b0;
    m_stall = 1'b0;
    m_cnt   = 0;
    for (int i = 0; i < 32; i++) m_last_wr[i] = -1000;
  endtask

  // One clock: predict from the rules, advance the DUT, compare.
  task automatic cycle();
    bit          accept, haz, any_wr;
    logic [31:0] h;
    int          rs1, rs2;
    chk("in_ready", in_ready, (mq.size() != DEPTH));
    accept = in_valid && (mq.size() != DEPTH);
    m_cyc++;
    if (mq.size() > 0) begin
      h   = mq[0];
      rs1 = h[20:16];
      rs2 = h[15:11];
      haz = (m_cyc - m_last_wr[rs1] <= HD) || (!h[28] && (m_cyc - m_last_wr[rs2] <= HD));
      if (!haz) begin
        m_instr = h; m_valid = 1'b1; m_stall = 1'b0;
        void'(mq.pop_front());
        if (h[27]) m_last_wr[h[25:21]] = m_cyc;
      end else begin
        m_instr = 32'h0; m_valid = 1'b0; m_stall = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end
    end else begin
      m_instr = 32'h0; m_valid = 1'b0; m_stall = 1'b0;
    end
    if (accept) mq.push_back(in_instr);
    any_wr = 1'b0;
    for (int i = 0; i < 32; i++) if (m_cyc - m_last_wr[i] < HD) any_wr = 1'b1;
    @(posedge clk);
    #1;
    chk("instr_out", instr_out, m_instr);
    chk("issue_valid", issue_valid, m_valid);
    chk("stall", stall, m_stall);
    chk("stall_count", stall_count, m_cnt);
    chk("busy", busy, (mq.size() > 0) || any_wr);
  endtask

  task automatic push_list(input logic [31:0] lst[$]);
    int idx = 0;
    for (int n = 0; n < 60 && idx < lst.size(); n++) begin
      bit acc;
      in_valid = 1'b1;
      in_instr = lst[idx];
      acc = (mq.size() != DEPTH);
      cycle();
      if (acc) idx++;
    end
    chk("push_list_done", idx, lst.size());
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [31:0] lst[$];
    logic [31:0] fresh;
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0;
    in_valid2 = 1'b0; in_instr2 = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_issue_valid", issue_valid, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_stall_count", stall_count, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    // Four independent instructions back-to-back
    lst.delete();
    for (int i = 1; i <= 4; i++) lst.push_back(mk(1'b1, 1'b0, i, 10, r2(11)));
    push_list(lst);
    idle(4);
    chk("indep_no_stall", stall_count, 16'd0);

    // Producer rd=5, consumer rs1=5: three bubbles
    lst.delete();
    lst.push_back(mk(1'b1, 1'b0, 5, 10, r2(11)));
    lst.push_back(mk(1'b1, 1'b0, 9, 5, r2(12)));
    push_list(lst);
    idle(8);
    chk("raw_three_bubbles", stall_count, 16'd3);

    // Immediate consumer whose IMM[15:11]=5 does not stall
    lst.delete();
    lst.push_back(mk(1'b1, 1'b0, 5, 10, r2(11)));
    lst.push_back(mk(1'b1, 1'b1, 9, 12, {5'd5, 11'h2AB}));
    push_list(lst);
    idle(6);
    chk("imm_ignores_rs2", stall_count, 16'd3);

    // Fill the FIFO behind a stalled head; order and backpressure via model
    lst.delete();
    lst.push_back(mk(1'b1, 1'b0, 6, 10, r2(11)));
    lst.push_back(mk(1'b1, 1'b0, 7, 6, r2(12)));
    for (int i = 0; i < 5; i++) lst.push_back(mk(1'b1, 1'b0, 20 + i, 12, r2(13)));
    push_list(lst);
    idle(12);

    // Reset during a stall with three queued
    lst.delete();
    lst.push_back(mk(1'b1, 1'b0, 7, 10, r2(11)));
    lst.push_back(mk(1'b1, 1'b0, 8, 7, r2(12)));
    lst.push_back(mk(1'b1, 1'b0, 9, 12, r2(13)));
    lst.push_back(mk(1'b1, 1'b0, 10, 12, r2(13)));
    push_list(lst);
    chk("pre_rst_stall", stall, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_instr_out", instr_out, 32'h0);
    chk("midrst_issue_valid", issue_valid, 1'b0);
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_stall_count", stall_count, 16'h0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    fresh = mk(1'b1, 1'b0, 11, 7, r2(8));
    in_valid = 1'b1; in_instr = fresh;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("fresh_issue_valid", issue_valid, 1'b1);
    chk("fresh_instr_out", instr_out, fresh);
    idle(3);

    // Randomized traffic with a small register pool to provoke hazards
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(3) != 0);
      in_instr = mk(1'($urandom_range(1)), 1'($urandom_range(1)),
                    $urandom_range(7), $urandom_range(7), r2($urandom_range(7)));
      cycle();
    end
    idle(10);

    // Saturation on the deep-window instance: self-dependent chain
    in_valid2 = 1'b1;
    in_instr2 = mk(1'b1, 1'b0, 5, 5, r2(5));
    repeat (HD2 + 2) @(posedge clk);
    #1;
    chk("sat_first_gap", stall_count2, 16'd64);
    repeat (67000) @(posedge clk);
    #1;
    chk("sat_hold", stall_count2, 16'hFFFF);
    repeat (70) @(posedge clk);
    #1;
    chk("sat_still", stall_count2, 16'hFFFF);
    in_valid2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
